// File: rtl/a_sqrtb_rr_sched_if.sv
// rtl/a_sqrtb_rr_sched_if.sv - requester-side bundle of the shared a*floor(sqrt(b)) scheduler
//
// Signals (N requesters, IDW-bit requester index):
//   req[N]        request level per requester, held until its ack
//   a_in/b_in     8-bit operands per requester, requester i at [8i+7:8i]
//   ack[N]        one-cycle pulse, operands of the granted requester captured
//   done[N]       one-cycle pulse, y_out/y_id valid for that requester
//   y_out[12]     last result, held until the next done
//   y_id[IDW]     requester owning y_out
//   busy          scheduler is not idle
//   ops_done[16]  wrapping count of completed operations
// Modports: master = requester side, slave = scheduler side.
interface a_sqrtb_rr_sched_if #(
    parameter int N   = 4,
    parameter int IDW = 3
);
    logic [N-1:0]   req;
    logic [8*N-1:0] a_in;
    logic [8*N-1:0] b_in;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [11:0]    y_out;
    logic [IDW-1:0] y_id;
    logic           busy;
    logic [15:0]    ops_done;

    modport master (
        output req, a_in, b_in,
        input  ack, done, y_out, y_id, busy, ops_done
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, done, y_out, y_id, busy, ops_done
    );
endinterface

// File: rtl/a_sqrtb_rr_sched.sv
// rtl/a_sqrtb_rr_sched.sv - round-robin scheduler sharing one a*floor(sqrt(b)) unit
//
// a_sqrtb: multi-cycle y = a*floor(sqrt(b)) unit.
//   clk, rst      clock, synchronous active-high reset
//   in_ready      operands a/b accepted on a rising edge where this is high
//   a, b          8-bit operands
//   y_ready       result valid; stays high until the next accept
//   y             12-bit result
//
// a_sqrtb_rr_sched: arbitrates N requesters onto one a_sqrtb instance.
//   clk, rst      clock, synchronous active-high reset (also resets the unit)
//   bus           a_sqrtb_rr_sched_if slave modport (req/operands in,
//                 ack/done/y_out/y_id/busy/ops_done out, all registered)

module a_sqrtb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        y_ready,
    output logic [11:0] y
);
    // Digit-by-digit square root: one result bit per cycle (4 cycles for an
    // 8-bit radicand), then one cycle for the multiply.
    logic [7:0] a_q;
    logic [7:0] op_q;
    logic [7:0] res_q;
    logic [7:0] one_q;
    logic       run_q;
    logic [8:0] trial;

    assign trial = {1'b0, res_q} + {1'b0, one_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            one_q   <= '0;
            run_q   <= 1'b0;
            y_ready <= 1'b0;
            y       <= '0;
        end else if (in_ready) begin
            a_q     <= a;
            op_q    <= b;
            res_q   <= '0;
            one_q   <= 8'h40;
            run_q   <= 1'b1;
            y_ready <= 1'b0;
        end else if (run_q) begin
            if (one_q != 8'd0) begin
                if ({1'b0, op_q} >= trial) begin
                    op_q  <= op_q - trial[7:0];
                    res_q <= (res_q >> 1) + one_q;
                end else begin
                    res_q <= res_q >> 1;
                end
                one_q <= one_q >> 2;
            end else begin
                // res_q <= 15 here, so the 12-bit product never truncates.
                y       <= {4'b0, a_q} * {4'b0, res_q};
                y_ready <= 1'b1;
                run_q   <= 1'b0;
            end
        end
    end
endmodule

module a_sqrtb_rr_sched #(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    a_sqrtb_rr_sched_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] g_q, g_d;
    logic [7:0]     a_q, a_d;
    logic [7:0]     b_q, b_d;
    logic           in_ready_q, in_ready_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [N-1:0]   done_q, done_d;
    logic [11:0]    y_q, y_d;
    logic [IDW-1:0] y_id_q, y_id_d;
    logic           busy_q, busy_d;
    logic [15:0]    ops_q, ops_d;

    logic           unit_y_ready;
    logic [11:0]    unit_y;

    logic           found;
    logic [IDW-1:0] gsel;
    int             idx;

    a_sqrtb u_unit (
        .clk      (clk),
        .rst      (rst),
        .in_ready (in_ready_q),
        .a        (a_q),
        .b        (b_q),
        .y_ready  (unit_y_ready),
        .y        (unit_y)
    );

    // First requesting index at or above the pointer, wrapping. The pointer
    // is moved past the last served requester, so it becomes lowest priority.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                gsel  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        a_d        = a_q;
        b_d        = b_q;
        in_ready_d = 1'b0;
        ack_d      = '0;
        done_d     = '0;
        y_d        = y_q;
        y_id_d     = y_id_q;
        ops_d      = ops_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d        = gsel;
                    a_d        = bus.a_in[8*gsel +: 8];
                    b_d        = bus.b_in[8*gsel +: 8];
                    ack_d[gsel] = 1'b1;
                    in_ready_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // The unit takes the operands on the edge leaving this state,
                // which also clears any stale y_ready before WAIT looks at it.
                state_d = WAIT;
            end
            WAIT: begin
                if (unit_y_ready) begin
                    y_d         = unit_y;
                    y_id_d      = g_q;
                    done_d[g_q] = 1'b1;
                    ops_d       = ops_q + 16'd1;
                    ptr_d       = (g_q == LAST_ID) ? '0 : g_q + 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            in_ready_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            y_q        <= '0;
            y_id_q     <= '0;
            busy_q     <= 1'b0;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            a_q        <= a_d;
            b_q        <= b_d;
            in_ready_q <= in_ready_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            y_q        <= y_d;
            y_id_q     <= y_id_d;
            busy_q     <= busy_d;
            ops_q      <= ops_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.y_out    = y_q;
    assign bus.y_id     = y_id_q;
    assign bus.busy     = busy_q;
    assign bus.ops_done = ops_q;
endmodule

// File: tb/tb_a_sqrtb_rr_sched.sv
// tb/tb_a_sqrtb_rr_sched.sv - randomized and directed bench for a_sqrtb_rr_sched
module tb_a_sqrtb_rr_sched;
    localparam int N   = 4;
    localparam int IDW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a_sqrtb_rr_sched_if #(.N(N), .IDW(IDW)) bus ();

    a_sqrtb_rr_sched #(.N(N), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int ref_arb(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Reference model state: pointer, in-flight grant, expected result and count.
    logic [N-1:0]   req_e;
    logic [8*N-1:0] a_e, b_e;
    logic           rst_e = 1'b1;
    int  mptr = 0, mg = 0, mexp = 0, mcount = 0;
    bit  inflight = 1'b0;
    int  ndones = 0;
    int  grant_log[$];
    int  dy_log[$];
    int  did_log[$];
    int  preload_seq = 0, preload_seen = 0;

    always @(posedge clk) begin
        req_e <= bus.req;
        a_e   <= bus.a_in;
        b_e   <= bus.b_in;
        rst_e <= rst;
    end

    always @(negedge clk) begin
        int g;
        if (preload_seq != preload_seen) begin
            preload_seen = preload_seq;
            mcount = 65535;
        end
        if (rst_e) begin
            mptr = 0;
            mcount = 0;
            inflight = 1'b0;
            if (bus.ack != '0 || bus.done != '0) check("pulse_in_reset", {bus.ack, bus.done}, 0);
        end else begin
            if (bus.ack != '0 && bus.done != '0) check("ack_done_overlap", 1, 0);
            if (bus.ack != '0) begin
                if (inflight) check("ack_while_inflight", 1, 0);
                g = ref_arb(req_e, mptr);
                check("ack_vec", 32'(bus.ack), (g < 0) ? 0 : (1 << g));
                if (g >= 0) begin
                    mg = g;
                    mexp = int'(a_e[8*g +: 8]) * isqrt(int'(b_e[8*g +: 8]));
                    inflight = 1'b1;
                    grant_log.push_back(g);
                end
            end
            if (bus.done != '0) begin
                check("done_vec", 32'(bus.done), inflight ? (1 << mg) : 0);
                check("y_out", 32'(bus.y_out), mexp);
                check("y_id", 32'(bus.y_id), mg);
                check("ops_done", 32'(bus.ops_done), (mcount + 1) & 16'hffff);
                mcount = (mcount + 1) & 16'hffff;
                mptr = (mg + 1) % N;
                inflight = 1'b0;
                ndones++;
                dy_log.push_back(int'(bus.y_out));
                did_log.push_back(int'(bus.y_id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        bus.a_in[8*i +: 8] = 8'(a);
        bus.b_in[8*i +: 8] = 8'(b);
    endtask

    task automatic wait_ack(input int i, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ack[i] && n < 40);
        if (!bus.ack[i]) check("ack_timeout", 0, 1);
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done[i] && n < 40);
        if (!bus.done[i]) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int i, input int a, input int b);
        int n;
        set_ops(i, a, b);
        bus.req[i] = 1'b1;
        wait_ack(i, n);
        bus.req[i] = 1'b0;
        wait_done(i);
    endtask

    task automatic settle(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        settle(1);
    endtask

    initial begin
        int n, base, d0;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        do_reset();

        check("rst_ack", 32'(bus.ack), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_y_out", 32'(bus.y_out), 0);
        check("rst_y_id", 32'(bus.y_id), 0);
        check("rst_ops", 32'(bus.ops_done), 0);

        // Single op, grant latency one cycle.
        set_ops(0, 10, 16);
        bus.req[0] = 1'b1;
        wait_ack(0, n);
        check("ack_latency", n, 1);
        check("busy_after_ack", 32'(bus.busy), 1);
        bus.req[0] = 1'b0;
        wait_done(0);
        check("single_y", 32'(bus.y_out), 40);
        check("single_id", 32'(bus.y_id), 0);
        check("single_ops", 32'(bus.ops_done), 1);
        tick();
        tick();
        check("idle_busy", 32'(bus.busy), 0);
        check("y_hold", 32'(bus.y_out), 40);

        run_op(0, 255, 255);
        check("max_y", 32'(bus.y_out), 3825);
        run_op(0, 200, 0);
        check("zero_y", 32'(bus.y_out), 0);

        // All four together from reset.
        do_reset();
        base = grant_log.size();
        d0 = dy_log.size();
        set_ops(0, 3, 4); set_ops(1, 5, 9); set_ops(2, 7, 25); set_ops(3, 9, 100);
        bus.req = 4'hf;
        for (int c = 0; c < 120 && dy_log.size() < d0 + 4; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
        end
        check("all4_count", dy_log.size() - d0, 4);
        if (dy_log.size() >= d0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("all4_order", grant_log[base + i], i);
                check("all4_id", did_log[d0 + i], i);
            end
            check("all4_y0", dy_log[d0], 6);
            check("all4_y1", dy_log[d0 + 1], 15);
            check("all4_y2", dy_log[d0 + 2], 35);
            check("all4_y3", dy_log[d0 + 3], 90);
        end
        settle(2);

        // Fairness: req[1] held, req[2] arrives while 1 is in flight.
        base = grant_log.size();
        set_ops(1, 4, 16); set_ops(2, 6, 36);
        bus.req[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 150 && n < 3; c++) begin
            tick();
            if (bus.ack != '0) begin
                n++;
                if (n == 1) bus.req[2] = 1'b1;
                if (bus.ack[2]) bus.req[2] = 1'b0;
                if (n == 3) bus.req[1] = 1'b0;
            end
        end
        bus.req = '0;
        settle(20);
        check("fair_count", grant_log.size() - base, 3);
        if (grant_log.size() >= base + 3) begin
            check("fair_g0", grant_log[base], 1);
            check("fair_g1", grant_log[base + 1], 2);
            check("fair_g2", grant_log[base + 2], 1);
        end

        // Drop request the cycle after ack; result still delivered once.
        set_ops(3, 50, 200);
        bus.req[3] = 1'b1;
        wait_ack(3, n);
        tick();
        bus.req[3] = 1'b0;
        wait_done(3);
        check("drop_y", 32'(bus.y_out), 700);
        check("drop_id", 32'(bus.y_id), 3);
        base = grant_log.size();
        settle(20);
        check("drop_no_regrant", grant_log.size() - base, 0);

        // Move pointer to 2, then abort an op on 2 mid-WAIT.
        run_op(1, 1, 4);
        settle(2);
        set_ops(2, 7, 49);
        bus.req[2] = 1'b1;
        wait_ack(2, n);
        bus.req[2] = 1'b0;
        tick();
        tick();
        d0 = ndones;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ack", 32'(bus.ack), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_y", 32'(bus.y_out), 0);
        check("abort_id", 32'(bus.y_id), 0);
        check("abort_ops", 32'(bus.ops_done), 0);
        settle(20);
        check("abort_no_done", ndones - d0, 0);
        base = grant_log.size();
        set_ops(0, 2, 81); set_ops(3, 3, 9);
        bus.req[0] = 1'b1;
        bus.req[3] = 1'b1;
        wait_ack(0, n);
        bus.req[0] = 1'b0;
        wait_done(0);
        check("post_rst_y", 32'(bus.y_out), 18);
        if (grant_log.size() > base) check("post_rst_ptr", grant_log[base], 0);
        for (int c = 0; c < 40 && bus.req[3]; c++) begin
            tick();
            if (bus.ack[3]) bus.req[3] = 1'b0;
        end
        settle(15);

        // Counter wrap.
        force dut.ops_q = 16'hffff;
        preload_seq++;
        tick();
        release dut.ops_q;
        tick();
        run_op(1, 1, 1);
        check("ops_wrap", 32'(bus.ops_done), 0);
        settle(2);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
                    set_ops(i, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
                    bus.req[i] = 1'b1;
                end
            end
        end
        // Drain: release each request once it has been acknowledged.
        for (int c = 0; c < 400 && (bus.req != '0 || bus.busy); c++) begin
            tick();
            for (int i = 0; i < N; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
        end
        settle(4);
        check("drain_inflight", 32'(inflight), 0);
        check("drain_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/a_sqrtb_rr_sched.md
# a_sqrtb_rr_sched

Round-robin scheduler that shares a single `a_sqrtb` unit (y = a·floor(sqrt(b))) between `N` independent requesters. It owns one internal `a_sqrtb` instance, captures one requester's operands per grant, and sequences the unit's `in_ready`/`y_ready` handshake. It returns the 12-bit result to the granted requester with a tagged done pulse. It sits between the client FSMs and the arithmetic datapath, so no client touches the unit directly.

## Interface
- `N`, 4: number of requesters, 2..8.
- `IDW`, 3: width of requester index, at least clog2(N).
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high; also drives the internal `a_sqrtb` reset.
- `req`  in  N  per-requester request level; bit i held high until `ack[i]`.
- `a_in`  in  8·N  operand a, requester i at bits [8i+7:8i]; held stable while `req[i]` is high.
- `b_in`  in  8·N  operand b, same packing.
- `ack`  out  N  one-cycle pulse; operands of requester i captured.
- `done`  out  N  one-cycle pulse; result for requester i valid on `y_out` this cycle.
- `y_out`  out  12  result; holds its value until the next `done`.
- `y_id`  out  IDW  index of the requester owning `y_out`.
- `busy`  out  1  high in every state except IDLE.
- `ops_done`  out  16  count of completed operations; wraps at 65535→0.

## Operation
- All outputs are registered. Reset values:
  - `ack`, `done`, `busy`: 0.
  - `y_out`, `y_id`, `ops_done`: 0.
  - RR pointer: 0, meaning requester 0 has highest priority.
  - FSM: IDLE.
  - Internal `in_ready`: 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req` bit is high, grant g = first requester with `req` high, searching from the pointer upward with wrap.
  - Latch `a_in[g]`, `b_in[g]` and g; pulse `ack[g]`; set internal `in_ready`=1; go to ISSUE.
- ISSUE: set `in_ready`=0; go to WAIT. The unit accepts the operands at the end of the grant cycle.
- WAIT: stay while the unit's `y_ready`=0. When `y_ready`=1:
  - Register `y_out` ← unit result, `y_id` ← g.
  - Pulse `done[g]`; increment `ops_done`; set pointer ← (g+1) mod N; go to RESP.
- RESP: deassert `done`; go to IDLE.
- Arbitration:
  - Exactly one grant per operation.
  - A requester that keeps `req` high after its `ack` is treated as a new request. It gets lowest priority for the next grant.
  - Requesters sampled in RESP are not granted until IDLE.
- Width rule: result = a·floor(sqrt(b)); maximum 255·15 = 3825, so 12 bits with no truncation.
- Boundaries:
  - A requester that drops `req` after `ack` still gets its `done`. Results are never discarded.
  - `req[i]` rising in the same cycle as `done[i]` is not granted in that cycle.
  - `rst` mid-operation aborts everything: the unit resets too, no `done` is issued, and all registers return to reset values on the next edge.
  - When `req`=0 in IDLE, the FSM stays in IDLE and all outputs hold.

## Timing
- Grant: `ack[g]` is high in the cycle after `req[g]` is sampled high in IDLE.
- Minimum turnaround is 3 cycles plus the unit latency: grant → ISSUE → WAIT (≥1 cycle, until `y_ready`) → RESP.
- Next grant comes no earlier than 1 cycle after `done`, so at most one operation is in flight.
- Stale-result guard: the unit's `y_ready` stays high from the previous op until its next accept. WAIT is entered only after ISSUE, and by then the unit has cleared `y_ready`.
- `done` and `ack` are never high in the same cycle.

## Test plan
- Single op:
  - `req[0]`, a=10, b=16 → `ack[0]` 1 cycle later; `done[0]` with `y_out`=40, `y_id`=0, `ops_done`=1.
  - a=255, b=255 → `y_out`=3825.
  - a=200, b=0 → `y_out`=0.
- All four `req` high together from reset, held until `ack` → grant order 0,1,2,3, each `done` tagged correctly.
  - Operands (3,4),(5,9),(7,25),(9,100) → results 6,15,35,90.
- Fairness: `req[1]` held high continuously while `req[2]` pulses in → grants alternate 1,2,1. Requester 1 is never granted twice while `req[2]` is pending.
- Drop after `ack`: `req[3]` deasserted the cycle after `ack[3]` → `done[3]` still arrives with the correct value; no further grant to 3.
- Reset mid-WAIT: assert `rst` for 1 cycle during WAIT →
  - no `done`; all outputs 0; pointer 0.
  - a subsequent op a=2, b=81 returns 18 correctly.
- `ops_done` preloaded near wrap by forcing 65535 → next completion reads 0.
